// File: rtl/exu_mdu_if.sv
// exu_mdu_if: request/response/flush bundle between EXU issue logic and the MDU
interface exu_mdu_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RIDX_W = 5
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [2:0]        op_i;
  logic [XLEN-1:0]   a_i;
  logic [XLEN-1:0]   b_i;
  logic [RIDX_W-1:0] rd_idx_i;
  logic              flush_i;
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [XLEN-1:0]   result_o;
  logic [RIDX_W-1:0] rd_idx_o;
  logic              busy_o;

  // Issue side: drives requests, flush and response acceptance
  modport master (
    output req_valid_i, op_i, a_i, b_i, rd_idx_i, flush_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, result_o, rd_idx_o, busy_o
  );

  // MDU side
  modport slave (
    input  req_valid_i, op_i, a_i, b_i, rd_idx_i, flush_i, resp_ready_i,
    output req_ready_o, resp_valid_o, result_o, rd_idx_o, busy_o
  );
endinterface

// File: rtl/exu_mdu.sv
// exu_mdu: XLEN-generic iterative RV-M unit (radix-2 shift-add multiply,
// restoring divide) with a one-cycle path for divide-by-zero and overflow.
module exu_mdu #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RIDX_W = 5
) (
  input logic      clk,
  input logic      rst,
  exu_mdu_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned ACC_W = 2 * XLEN;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [RIDX_W-1:0] rd_q, rd_d;
  logic              neg_q, neg_d;     // negate the final product/quotient/remainder
  logic [XLEN-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [ACC_W-1:0]  acc_q, acc_d;     // mul: {partial, multiplier}; div: {rem, dividend/quot}
  logic [XLEN-1:0]   result_q, result_d;

  // Request decode: signedness, magnitudes and fast-path detection
  logic            a_sgn, b_sgn, sa, sb, fast;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;
  always_comb begin
    a_sgn = (bus.op_i == OP_MULH) || (bus.op_i == OP_MULHSU) ||
            (bus.op_i == OP_DIV)  || (bus.op_i == OP_REM);
    b_sgn = (bus.op_i == OP_MULH) || (bus.op_i == OP_DIV) || (bus.op_i == OP_REM);
    sa    = a_sgn & bus.a_i[XLEN-1];
    sb    = b_sgn & bus.b_i[XLEN-1];
    a_mag = sa ? (XLEN'(0) - bus.a_i) : bus.a_i;
    b_mag = sb ? (XLEN'(0) - bus.b_i) : bus.b_i;
    fast  = 1'b0;
    fast_res = '0;
    if (bus.op_i[2]) begin
      if (bus.b_i == '0) begin
        fast     = 1'b1;
        fast_res = bus.op_i[1] ? bus.a_i : '1;
      end else if (!bus.op_i[0] && (bus.a_i == MOST_NEG) && (bus.b_i == '1)) begin
        fast     = 1'b1;
        fast_res = bus.op_i[1] ? '0 : bus.a_i;
      end
    end
  end

  // One iteration of the shift-add or restoring-divide step
  logic [XLEN:0]    mul_sum, div_sh, div_diff;
  logic [ACC_W-1:0] mul_nxt, div_nxt, step_nxt;
  always_comb begin
    mul_sum  = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
    div_sh   = {acc_q[ACC_W-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    div_nxt  = {(div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0]),
                acc_q[XLEN-2:0], ~div_diff[XLEN]};
    step_nxt = op_q[2] ? div_nxt : mul_nxt;
  end

  // Sign fix and result selection for the last iteration
  logic [ACC_W-1:0] prod_fix;
  logic [XLEN-1:0]  quo, rem, fin_res;
  always_comb begin
    prod_fix = neg_q ? (ACC_W'(0) - step_nxt) : step_nxt;
    quo      = step_nxt[XLEN-1:0];
    rem      = step_nxt[ACC_W-1:XLEN];
    case (op_q)
      OP_MUL:        fin_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:          fin_res = prod_fix[ACC_W-1:XLEN];
      3'd4, 3'd5:    fin_res = neg_q ? (XLEN'(0) - quo) : quo;
      default:       fin_res = neg_q ? (XLEN'(0) - rem) : rem;
    endcase
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          op_d  = bus.op_i;
          rd_d  = bus.rd_idx_i;
          neg_d = (bus.op_i[2] && bus.op_i[1]) ? sa : (sa ^ sb);
          if (fast) begin
            result_d = fast_res;
            state_d  = S_DONE;
          end else begin
            cnt_d   = CNT_W'(XLEN);
            opnd_d  = bus.op_i[2] ? b_mag : a_mag;
            acc_d   = {{XLEN{1'b0}}, (bus.op_i[2] ? a_mag : b_mag)};
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = step_nxt;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = fin_res;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign bus.req_ready_o  = (state_q == S_IDLE);
  assign bus.resp_valid_o = (state_q == S_DONE) & ~bus.flush_i;
  assign bus.busy_o       = (state_q != S_IDLE);
  assign bus.result_o     = result_q;
  assign bus.rd_idx_o     = rd_q;

endmodule
